// File: rtl/clb_if.sv
// clb_if: signal bundle between the routing fabric and one logic cluster.
//   clb_in    : cluster inputs (I bits)
//   ce        : BLE flip-flop clock enable
//   clb_out   : one output per BLE (N bits)
//   scan_in   : configuration serial in
//   scan_en   : configuration shift enable
//   scan_out  : configuration serial out, feeds the next tile in the chain
//   cfg_valid : configuration loaded and logic live
//   cfg_err   : last load had the wrong bit count
// master = fabric side, slave = cluster side.
interface clb_if #(
    parameter int I = 10,
    parameter int N = 4
);
    logic [I-1:0] clb_in;
    logic         ce;
    logic [N-1:0] clb_out;
    logic         scan_in;
    logic         scan_en;
    logic         scan_out;
    logic         cfg_valid;
    logic         cfg_err;

    modport master (
        output clb_in, ce, scan_in, scan_en,
        input  clb_out, scan_out, cfg_valid, cfg_err
    );

    modport slave (
        input  clb_in, ce, scan_in, scan_en,
        output clb_out, scan_out, cfg_valid, cfg_err
    );
endinterface

// File: rtl/clb_cluster.sv
// clb_cluster: N basic logic elements (K-LUT + flip-flop) behind a local
// crossbar that picks from the I cluster inputs and the N BLE register
// outputs. All configuration arrives on one scan chain; a load FSM checks
// that exactly CFG_BITS bits were shifted before the logic goes live.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : clb_if slave modport (cluster I/O and scan chain)

// One BLE: crossbar selects, LUT, flip-flop, output mux.
//   field : this BLE's config slice {mode, sel[K-1]..sel[0], table}
//   src   : crossbar sources {q of all BLEs, clb_in}
//   run   : cluster is in RUN
//   hold  : RUN and not shifting this edge; otherwise q clears
module clb_ble #(
    parameter int K = 4,
    parameter int S = 4,
    parameter int W = 14,
    parameter int B = 2**K + K*S + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [B-1:0] field,
    input  logic [W-1:0] src,
    input  logic         run,
    input  logic         hold,
    input  logic         ce,
    output logic         q,
    output logic         out
);
    logic [2**K-1:0] tbl;
    logic [K-1:0]    addr;
    logic            lut;
    logic            mode;

    assign tbl  = field[2**K-1:0];
    assign mode = field[B-1];

    // Select codes at or beyond W match no source and read as 0.
    always_comb begin
        addr = '0;
        for (int k = 0; k < K; k++)
            for (int s = 0; s < W; s++)
                if (field[2**K + k*S +: S] == S'(s))
                    addr[k] = src[s];
    end

    assign lut = tbl[addr];

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= 1'b0;
        else if (!hold)
            q <= 1'b0;
        else if (ce)
            q <= lut;
    end

    assign out = run ? (mode ? q : lut) : 1'b0;
endmodule

module clb_cluster #(
    parameter int K = 4,
    parameter int N = 4,
    parameter int I = 10
) (
    input logic clk,
    input logic rst_n,
    clb_if.slave bus
);
    localparam int S        = $clog2(I + N);
    localparam int B        = 2**K + K*S + 1;
    localparam int CFG_BITS = N * B;
    localparam int CW       = $clog2(CFG_BITS + 2);

    localparam logic [1:0] UNCFG = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    logic [CFG_BITS-1:0] cfg;
    logic [CW-1:0]       cnt;
    logic [1:0]          state;
    logic [N-1:0]        q;
    logic                run;
    logic                hold;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cfg <= '0;
        else if (bus.scan_en)
            cfg <= {cfg[CFG_BITS-2:0], bus.scan_in};
    end

    // The edge that enters SHIFT already shifts one bit, hence cnt <= 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= UNCFG;
            cnt   <= '0;
        end else if (bus.scan_en) begin
            state <= SHIFT;
            if (state != SHIFT)
                cnt <= CW'(1);
            else if (cnt != CW'(CFG_BITS + 1))
                cnt <= cnt + CW'(1);
        end else if (state == SHIFT) begin
            state <= (cnt == CW'(CFG_BITS)) ? RUN : ERR;
        end
    end

    assign run           = (state == RUN);
    assign hold          = run && !bus.scan_en;
    assign bus.scan_out  = cfg[CFG_BITS-1];
    assign bus.cfg_valid = run;
    assign bus.cfg_err   = (state == ERR);

    // Crossbar reads only registered q for feedback, so no comb loops.
    logic [I+N-1:0] src;
    assign src = {q, bus.clb_in};

    for (genvar j = 0; j < N; j++) begin : g_ble
        clb_ble #(.K(K), .S(S), .W(I + N), .B(B)) u_ble (
            .clk   (clk),
            .rst_n (rst_n),
            .field (cfg[j*B +: B]),
            .src   (src),
            .run   (run),
            .hold  (hold),
            .ce    (bus.ce),
            .q     (q[j]),
            .out   (bus.clb_out[j])
        );
    end
endmodule

// File: tb/tb_clb_cluster.sv
// tb_clb_cluster: directed bench for clb_cluster (K=4, N=4, I=10).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_clb_cluster;
    localparam int CFG_BITS = 132;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    clb_if #(.I(10), .N(4)) bus ();

    clb_cluster #(.K(4), .N(4), .I(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CFG_BITS-1:0] obs,
                       input logic [CFG_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] mk(input logic [15:0] t,
                                       input logic [3:0] a, b, c, d,
                                       input logic m);
        return {m, d, c, b, a, t};
    endfunction

    // Shift nbits MSB first; bits above the word are dummy ones.
    task automatic load(input logic [CFG_BITS-1:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.scan_en = 1'b1;
            bus.scan_in = (i < CFG_BITS) ? w[i] : 1'b1;
            tick();
        end
        bus.scan_en = 1'b0;
        tick();
    endtask

    logic [CFG_BITS-1:0] cw;
    logic [263:0]        pat;

    initial begin
        cw = '0;
        cw[0  +: 33] = mk(16'h8000, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
        cw[33 +: 33] = mk(16'h6996, 4'd4, 4'd5, 4'd6, 4'd7, 1'b1);
        cw[66 +: 33] = mk(16'h5555, 4'd12, 4'd0, 4'd0, 4'd0, 1'b1);

        // Reset wins over scan_en.
        rst_n = 1'b0;
        bus.clb_in = '0;
        bus.ce = 1'b1;
        bus.scan_en = 1'b1;
        bus.scan_in = 1'($urandom_range(0, 1));
        tick();
        bus.scan_in = 1'($urandom_range(0, 1));
        tick();
        chk("rst_clb_out", bus.clb_out, 0);
        chk("rst_scan_out", bus.scan_out, 0);
        chk("rst_cfg_valid", bus.cfg_valid, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        chk("rst_cnt", dut.cnt, 0);

        // Unconfigured cluster stays silent.
        rst_n = 1'b1;
        bus.scan_en = 1'b0;
        bus.clb_in = '1;
        tick();
        tick();
        chk("uncfg_clb_out", bus.clb_out, 0);
        chk("uncfg_valid", bus.cfg_valid, 0);

        load(cw, CFG_BITS);
        chk("load_valid", bus.cfg_valid, 1);
        chk("load_err", bus.cfg_err, 0);

        // Combinational AND4, same cycle.
        bus.clb_in = 10'h00F; #1;
        chk("and4_F", bus.clb_out[0], 1);
        bus.clb_in = 10'h00E; #1;
        chk("and4_E", bus.clb_out[0], 0);

        // Registered XOR over clb_in[7:4].
        bus.clb_in = 10'h010; #1;
        chk("xor_pre_edge", bus.clb_out[1], 0);
        tick();
        chk("xor_1", bus.clb_out[1], 1);
        bus.clb_in = 10'h030; #1;
        chk("xor_hold_until_edge", bus.clb_out[1], 1);
        tick();
        chk("xor_0", bus.clb_out[1], 0);
        bus.clb_in = 10'h070;
        tick();
        chk("xor_1b", bus.clb_out[1], 1);
        bus.ce = 1'b0;
        bus.clb_in = 10'h000; tick(); chk("xor_ce0_a", bus.clb_out[1], 1);
        bus.clb_in = 10'h030; tick(); chk("xor_ce0_b", bus.clb_out[1], 1);
        bus.clb_in = 10'h0F0; tick(); chk("xor_ce0_c", bus.clb_out[1], 1);

        // A shift edge in RUN drops logic; a 1-bit load then errors.
        bus.scan_en = 1'b1;
        bus.scan_in = 1'b0;
        tick();
        chk("run_shift_valid", bus.cfg_valid, 0);
        chk("run_shift_out", bus.clb_out, 0);
        bus.scan_en = 1'b0;
        tick();
        chk("short1_err", bus.cfg_err, 1);

        // Feedback toggle on BLE2.
        bus.ce = 1'b1;
        bus.clb_in = '0;
        load(cw, CFG_BITS);
        chk("tog_0", bus.clb_out[2], 0);
        tick(); chk("tog_1", bus.clb_out[2], 1);
        tick(); chk("tog_2", bus.clb_out[2], 0);
        tick(); chk("tog_3", bus.clb_out[2], 1);
        bus.ce = 1'b0;
        tick(); tick();
        chk("tog_frozen", bus.clb_out[2], 1);
        chk("ble3_zero", bus.clb_out[3], 0);
        bus.ce = 1'b1;

        // Length checks.
        bus.clb_in = 10'h00F;
        load(cw, CFG_BITS - 1);
        chk("len131_err", bus.cfg_err, 1);
        chk("len131_valid", bus.cfg_valid, 0);
        chk("len131_out", bus.clb_out, 0);
        load(cw, CFG_BITS + 1);
        chk("len133_err", bus.cfg_err, 1);
        chk("len133_cnt_sat", dut.cnt, CFG_BITS + 1);
        chk("len133_cfg_last", dut.cfg, cw);
        load(cw, CFG_BITS);
        chk("len132_valid", bus.cfg_valid, 1);
        chk("len132_err", bus.cfg_err, 0);

        // Chain: bit m reappears on scan_out after edge m+131.
        for (int i = 0; i < 264; i++) pat[i] = 1'($urandom_range(0, 1));
        for (int m = 0; m < 264; m++) begin
            bus.scan_en = 1'b1;
            bus.scan_in = pat[m];
            tick();
            if (m >= CFG_BITS - 1)
                chk($sformatf("chain_%0d", m), bus.scan_out, pat[m-(CFG_BITS-1)]);
        end
        bus.scan_en = 1'b0;
        tick();
        chk("overshift_err", bus.cfg_err, 1);

        // Reset mid-shift discards the partial load.
        for (int i = 0; i < 50; i++) begin
            bus.scan_en = 1'b1;
            bus.scan_in = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("midrst_cfg", dut.cfg, 0);
        chk("midrst_cnt", dut.cnt, 0);
        chk("midrst_scan_out", bus.scan_out, 0);
        chk("midrst_valid", bus.cfg_valid, 0);
        chk("midrst_err", bus.cfg_err, 0);
        rst_n = 1'b1;
        bus.scan_en = 1'b0;
        tick();
        load(cw, CFG_BITS);
        chk("reload_valid", bus.cfg_valid, 1);
        bus.clb_in = 10'h00F; #1;
        chk("reload_and4", bus.clb_out[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
